// File: rtl/ram_arb_pkg.sv
// Shared encodings for the RAM arbiter: priority modes, lock state, index width helper.
package ram_arb_pkg;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef enum logic {
        LK_UNLOCKED = 1'b0,
        LK_LOCKED   = 1'b1
    } lock_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        while (((1 << r) < n) && (r < 31)) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot winner from an eligible mask: round-robin from ptr_i, or lowest index in fixed mode.
// Purely combinational; an empty mask yields an all-zero winner.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int MODE = PRIO_RR
) (
    input  logic [NCH-1:0]          elig_i,
    input  logic [clog2(NCH)-1:0]   ptr_i,
    output logic [NCH-1:0]          win_o
);

    localparam int IW = clog2(NCH);
    localparam logic [IW:0] NCH_W = (IW+1)'(NCH);

    logic          found;
    logic [IW:0]   j;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < NCH; i++) begin
            // Candidate index walks from the pointer and wraps past NCH-1.
            j = (MODE == PRIO_FIXED) ? (IW+1)'(i) : ({1'b0, ptr_i} + (IW+1)'(i));
            if (j >= NCH_W) j = j - NCH_W;
            if (!found && elig_i[j[IW-1:0]]) begin
                win_o[j[IW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Multi-channel single-port RAM arbiter with lock support; grant one cycle after request,
// read data RD_LAT+1 cycles after grant. Losers simply hold their request (no other backpressure).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [NCH-1:0]      iREQ,
    input  logic [NCH-1:0]      iWE,
    input  logic [NCH-1:0]      iLOCK,
    input  logic [NCH*AW-1:0]   iADDR,
    input  logic [NCH*DW-1:0]   iWDATA,
    output logic [NCH-1:0]      oGNT,
    output logic [NCH-1:0]      oRVALID,
    output logic [DW-1:0]       oRDATA,
    output logic                oRAM_CE,
    output logic                oRAM_RD,
    output logic                oRAM_WR,
    output logic [AW-1:0]       oRAM_ADDR,
    output logic [DW-1:0]       oRAM_DATA_WR,
    input  logic [DW-1:0]       iRAM_DATA_RD
);

    localparam int IW = clog2(NCH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH-1);

    logic [NCH-1:0]  gnt_q, rvalid_q, rvalid_d;
    logic            ram_ce_q, ram_rd_q, ram_wr_q;
    logic [AW-1:0]   ram_addr_q;
    logic [DW-1:0]   ram_wdat_q, rdata_q, rdata_d;
    logic [IW-1:0]   gnt_idx_q, ptr_q, ptr_d;
    lock_state_e     lock_state_q;
    logic [IW-1:0]   lock_idx_q;
    logic            tag_vld_q [RD_LAT];
    logic [IW-1:0]   tag_idx_q [RD_LAT];

    logic [NCH-1:0]  lock_mask, elig, win_oh;
    logic [IW-1:0]   win_idx;
    logic            win_vld;

    // A channel granted this cycle sits out this cycle's sampling; a lock excludes everyone else.
    assign lock_mask = (lock_state_q == LK_LOCKED) ? (NCH'(1) << lock_idx_q) : '1;
    assign elig      = iREQ & ~gnt_q & lock_mask;

    rr_arbiter #(
        .NCH  (NCH),
        .MODE (PRIO_MODE)
    ) u_rr_arbiter (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .win_o  (win_oh)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win_oh[i]) win_idx = IW'(i);
        end
    end

    assign win_vld  = |win_oh;
    assign ptr_d    = (win_idx == LAST_IDX) ? '0 : win_idx + IW'(1);
    assign rvalid_d = tag_vld_q[RD_LAT-1] ? (NCH'(1) << tag_idx_q[RD_LAT-1]) : '0;
    assign rdata_d  = tag_vld_q[RD_LAT-1] ? iRAM_DATA_RD : '0;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            gnt_q      <= '0;
            ram_ce_q   <= 1'b0;
            ram_rd_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_wdat_q <= '0;
            gnt_idx_q  <= '0;
            ptr_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
            end
        end else begin
            gnt_q      <= win_oh;
            ram_ce_q   <= win_vld;
            ram_rd_q   <= win_vld & ~iWE[win_idx];
            ram_wr_q   <= win_vld & iWE[win_idx];
            ram_addr_q <= win_vld ? iADDR[int'(win_idx)*AW +: AW] : '0;
            ram_wdat_q <= win_vld ? iWDATA[int'(win_idx)*DW +: DW] : '0;
            gnt_idx_q  <= win_idx;
            if (win_vld) ptr_q <= ptr_d;
            // Tag enters as the RAM sees the read and lines up with iRAM_DATA_RD at the tail.
            tag_vld_q[0] <= ram_rd_q;
            tag_idx_q[0] <= gnt_idx_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            lock_state_q <= LK_UNLOCKED;
            lock_idx_q   <= '0;
        end else if (win_vld) begin
            case (lock_state_q)
                LK_UNLOCKED: begin
                    if (iLOCK[win_idx]) begin
                        lock_state_q <= LK_LOCKED;
                        lock_idx_q   <= win_idx;
                    end
                end
                LK_LOCKED: begin
                    if (!iLOCK[win_idx]) lock_state_q <= LK_UNLOCKED;
                end
                default: lock_state_q <= LK_UNLOCKED;
            endcase
        end
    end

    assign oGNT         = gnt_q;
    assign oRVALID      = rvalid_q;
    assign oRDATA       = rdata_q;
    assign oRAM_CE      = ram_ce_q;
    assign oRAM_RD      = ram_rd_q;
    assign oRAM_WR      = ram_wr_q;
    assign oRAM_ADDR    = ram_addr_q;
    assign oRAM_DATA_WR = ram_wdat_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: RR/RD_LAT=1, fixed/RD_LAT=1 and RR/RD_LAT=3 instances share one stimulus.
module tb_ram_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req, we, lock;
    logic [31:0]  addr;
    logic [127:0] wdata;

    logic [3:0]  gnt_a, rvld_a, gnt_f, rvld_f, gnt_c, rvld_c;
    logic [31:0] rdata_a, rdata_f, rdata_c, wdat_a, wdat_f, wdat_c;
    logic        ce_a, rd_a, wr_a, ce_f, rd_f, wr_f, ce_c, rd_c, wr_c;
    logic [7:0]  addr_a, addr_f, addr_c;
    logic [31:0] ram_a_q;
    logic [31:0] ram_c_q [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [7:0] a);
        return {16'hBEEF, a, ~a};
    endfunction

    // RAM models: RD_LAT=1 for instance a, RD_LAT=3 for instance c.
    always_ff @(posedge clk) begin
        ram_a_q    <= rd_a ? word_of(addr_a) : 32'h0;
        ram_c_q[0] <= rd_c ? word_of(addr_c) : 32'h0;
        ram_c_q[1] <= ram_c_q[0];
        ram_c_q[2] <= ram_c_q[1];
    end

    ram_arbiter #(.NCH(4), .AW(8), .DW(32), .RD_LAT(1), .PRIO_MODE(0)) u_dut_a (
        .iCLK(clk), .iRST(rst), .iREQ(req), .iWE(we), .iLOCK(lock), .iADDR(addr), .iWDATA(wdata),
        .oGNT(gnt_a), .oRVALID(rvld_a), .oRDATA(rdata_a), .oRAM_CE(ce_a), .oRAM_RD(rd_a),
        .oRAM_WR(wr_a), .oRAM_ADDR(addr_a), .oRAM_DATA_WR(wdat_a), .iRAM_DATA_RD(ram_a_q));

    ram_arbiter #(.NCH(4), .AW(8), .DW(32), .RD_LAT(1), .PRIO_MODE(1)) u_dut_f (
        .iCLK(clk), .iRST(rst), .iREQ(req), .iWE(we), .iLOCK(lock), .iADDR(addr), .iWDATA(wdata),
        .oGNT(gnt_f), .oRVALID(rvld_f), .oRDATA(rdata_f), .oRAM_CE(ce_f), .oRAM_RD(rd_f),
        .oRAM_WR(wr_f), .oRAM_ADDR(addr_f), .oRAM_DATA_WR(wdat_f), .iRAM_DATA_RD(32'h0));

    ram_arbiter #(.NCH(4), .AW(8), .DW(32), .RD_LAT(3), .PRIO_MODE(0)) u_dut_c (
        .iCLK(clk), .iRST(rst), .iREQ(req), .iWE(we), .iLOCK(lock), .iADDR(addr), .iWDATA(wdata),
        .oGNT(gnt_c), .oRVALID(rvld_c), .oRDATA(rdata_c), .oRAM_CE(ce_c), .oRAM_RD(rd_c),
        .oRAM_WR(wr_c), .oRAM_ADDR(addr_c), .oRAM_DATA_WR(wdat_c), .iRAM_DATA_RD(ram_c_q[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        step(); step();
        chk("rst_gnt", gnt_a, 0);
        chk("rst_rvalid", rvld_a, 0);
        chk("rst_rdata", rdata_a, 0);
        chk("rst_strobes", {ce_a, rd_a, wr_a}, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_wdat", wdat_a, 0);

        // Single read: ch2 reads 0x10
        rst = 1'b0; req = 4'b0100; addr[16 +: 8] = 8'h10;
        step();
        chk("rd_gnt", gnt_a, 4'b0100);
        chk("rd_strobes", {ce_a, rd_a, wr_a}, 3'b110);
        chk("rd_addr", addr_a, 8'h10);
        req = '0;
        step();
        chk("rd_gnt_drop", gnt_a, 0);
        chk("rd_rvalid_early", rvld_a, 0);
        step();
        chk("rd_rvalid", rvld_a, 4'b0100);
        chk("rd_rdata", rdata_a, 32'hBEEF_10EF);
        chk("rd3_rvalid_early", rvld_c, 0);
        step();
        chk("rd_rvalid_end", rvld_a, 0);
        chk("rd_rdata_zero", rdata_a, 0);
        chk("rd3_rvalid_early2", rvld_c, 0);
        step();
        chk("rd3_rvalid", rvld_c, 4'b0100);
        chk("rd3_rdata", rdata_c, 32'hBEEF_10EF);

        // Single write: ch1 writes 0xDEADBEEF to 0x33
        req = 4'b0010; we = 4'b0010; addr[8 +: 8] = 8'h33; wdata[32 +: 32] = 32'hDEADBEEF;
        step();
        chk("wr_gnt", gnt_a, 4'b0010);
        chk("wr_strobes", {ce_a, rd_a, wr_a}, 3'b101);
        chk("wr_addr", addr_a, 8'h33);
        chk("wr_wdat", wdat_a, 32'hDEADBEEF);
        req = '0;
        step();
        step();
        chk("wr_no_rvalid", rvld_a, 0);

        // Round-robin: all channels request from within reset
        rst = 1'b1; req = 4'b1111; we = 4'b1111;
        addr = 32'h4342_4140;
        step(); step();
        chk("rr_in_reset", gnt_a, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_gnt", gnt_a, 4'b0001 << (i % 4));
            chk("rr_addr", addr_a, 8'h40 + 8'(i % 4));
        end

        // Fixed priority: ch1 and ch3 alternate
        req = '0;
        step();
        chk("fx_idle", gnt_f, 0);
        req = 4'b1010; we = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("fx_gnt", gnt_f, (i % 2 == 0) ? 4'b0010 : 4'b1000);
        end

        // Lock: ch0 locked read of 0x20, then unlocking write, ch1 waits throughout
        rst = 1'b1; req = '0; we = '0;
        step();
        rst = 1'b0; req = 4'b0011; lock = 4'b0001;
        addr = 32'h0000_5520; wdata[31:0] = 32'h12345678;
        step();
        chk("lk_rd_gnt", gnt_a, 4'b0001);
        chk("lk_rd_strobe", rd_a, 1);
        chk("lk_rd_addr", addr_a, 8'h20);
        we = 4'b0001; lock = 4'b0000;
        step();
        chk("lk_hold_gnt", gnt_a, 0);
        chk("lk_hold_ce", ce_a, 0);
        step();
        chk("lk_wr_gnt", gnt_a, 4'b0001);
        chk("lk_wr_strobe", wr_a, 1);
        chk("lk_wr_wdat", wdat_a, 32'h12345678);
        chk("lk_rvalid", rvld_a, 4'b0001);
        chk("lk_rdata", rdata_a, 32'hBEEF_20DF);
        req = 4'b0010;
        step();
        chk("lk_ch1_gnt", gnt_a, 4'b0010);
        req = '0;

        // Reset mid-read on the RD_LAT=3 instance
        rst = 1'b1; we = '0;
        step();
        rst = 1'b0; req = 4'b0001; addr = 32'h0000_0030;
        step();
        chk("mr_rd_gnt", gnt_c, 4'b0001);
        chk("mr_rd_strobe", rd_c, 1);
        req = '0;
        step();
        rst = 1'b1; req = 4'b1111; we = 4'b1111;
        step();
        chk("mr_rst_gnt", gnt_c, 0);
        chk("mr_rst_rvalid", rvld_c, 0);
        rst = 1'b0;
        step();
        chk("mr_first_gnt", gnt_c, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mr_no_rvalid", rvld_c, 0);
            chk("mr_rdata_zero", rdata_c, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
